// File: rtl/aipp_parser_axis_mc_if.sv
// AXI4-Stream beat channel carrying AIPP header/payload beats into the parser.
interface aipp_parser_axis_mc_if #(
    parameter int TDATA_W = 64
);
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aipp_parser_axis_mc.sv
// AIPP header parser: reassembles a 128-bit header from HB beats, queues accepted
// pre-charge commands for the VRM rails and pulses the target rail on hand-off.
//
// state      | meaning
// ST_HDR     | collecting header beats into beat_mem, decode on beat HB-1
// ST_DISCARD | header done, swallowing payload beats until tlast
module aipp_parser_axis_mc #(
    parameter int TDATA_W    = 64,
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TRIG_CYC   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    aipp_parser_axis_mc_if.slave          s_axis,
    output logic                          m_cmd_tvalid,
    input  logic                          m_cmd_tready,
    output logic [31:0]                   m_cmd_delay_us,
    output logic [31:0]                   m_cmd_voltage_mv,
    output logic [3:0]                    m_cmd_chan,
    output logic [N_CH-1:0]               trigger_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              pkt_ok_cnt,
    output logic [CNT_W-1:0]              pkt_drop_cnt
);
    localparam int HB = 128 / TDATA_W;
    localparam int BW = (HB > 1) ? $clog2(HB) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TRIG_CYC + 1);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(HB - 1);
    localparam logic [AW:0]      FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0]    TRIG_LOAD = TW'(TRIG_CYC);
    localparam logic [4:0]       N_CH_L    = 5'(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {ST_HDR, ST_DISCARD} state_t;

    typedef struct packed {
        logic [31:0] delay;
        logic [31:0] voltage;
        logic [3:0]  chan;
    } cmd_t;

    state_t             state;
    logic [BW-1:0]      beat_cnt;
    logic [TDATA_W-1:0] beat_mem [HB];
    cmd_t               fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [TW-1:0]      trig_tmr [N_CH];

    logic [127:0] hdr;
    logic         hdr_unused;
    logic         beat_acc;
    logic         hdr_done;
    logic         hdr_ok;
    logic         push;
    logic         pop;
    logic         fifo_full;

    // Header view: stored beats below the one currently on the bus.
    always_comb begin
        hdr = '0;
        for (int i = 0; i < HB; i++) begin
            hdr[i*TDATA_W +: TDATA_W] = (i == HB - 1) ? s_axis.tdata : beat_mem[i];
        end
    end

    assign hdr_unused = ^hdr[127:76];

    assign fifo_full     = (fifo_level == FULL_LVL);
    assign s_axis.tready = (state == ST_DISCARD) || !fifo_full;
    assign beat_acc      = s_axis.tvalid && s_axis.tready;
    assign hdr_done      = beat_acc && (state == ST_HDR) && (beat_cnt == LAST_BEAT);
    assign hdr_ok        = (hdr[7:0] == 8'h10) && ({1'b0, hdr[75:72]} < N_CH_L);
    assign push          = hdr_done && hdr_ok;
    assign m_cmd_tvalid  = (fifo_level != '0);
    assign pop           = m_cmd_tvalid && m_cmd_tready;

    assign {m_cmd_delay_us, m_cmd_voltage_mv, m_cmd_chan} = fifo_mem[rd_ptr];

    always_comb begin
        trigger_out = '0;
        for (int i = 0; i < N_CH; i++) begin
            trigger_out[i] = (trig_tmr[i] != '0);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_HDR;
            beat_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
            for (int i = 0; i < HB; i++)         beat_mem[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            for (int i = 0; i < N_CH; i++)       trig_tmr[i] <= '0;
        end else begin
            if (beat_acc) begin
                case (state)
                    ST_HDR: begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= s_axis.tlast ? ST_HDR : ST_DISCARD;
                            if (!hdr_ok && pkt_drop_cnt != CNT_MAX)
                                pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
                        end else if (s_axis.tlast) begin
                            beat_cnt <= '0;
                            if (pkt_drop_cnt != CNT_MAX)
                                pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
                        end else begin
                            beat_mem[beat_cnt] <= s_axis.tdata;
                            beat_cnt           <= beat_cnt + 1'b1;
                        end
                    end
                    ST_DISCARD: begin
                        if (s_axis.tlast)
                            state <= ST_HDR;
                    end
                    default: state <= ST_HDR;
                endcase
            end

            if (push) begin
                fifo_mem[wr_ptr] <= '{delay: hdr[39:8], voltage: hdr[71:40], chan: hdr[75:72]};
                wr_ptr           <= wr_ptr + 1'b1;
                if (pkt_ok_cnt != CNT_MAX)
                    pkt_ok_cnt <= pkt_ok_cnt + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;

            // A repeat pop on a busy rail restarts its pulse rather than extending it.
            for (int i = 0; i < N_CH; i++) begin
                if (pop && m_cmd_chan == 4'(i))
                    trig_tmr[i] <= TRIG_LOAD;
                else if (trig_tmr[i] != '0)
                    trig_tmr[i] <= trig_tmr[i] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aipp_parser_axis_mc.sv
// Directed bench for aipp_parser_axis_mc at TDATA_W=64, N_CH=4, FIFO_DEPTH=8, TRIG_CYC=4.
module tb_aipp_parser_axis_mc;
    localparam int TDATA_W    = 64;
    localparam int N_CH       = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int TRIG_CYC   = 4;
    localparam int CNT_W      = 16;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b1;
    logic              m_cmd_tready = 1'b0;
    logic              m_cmd_tvalid;
    logic [31:0]       m_cmd_delay_us;
    logic [31:0]       m_cmd_voltage_mv;
    logic [3:0]        m_cmd_chan;
    logic [N_CH-1:0]   trigger_out;
    logic [3:0]        fifo_level;
    logic [CNT_W-1:0]  pkt_ok_cnt;
    logic [CNT_W-1:0]  pkt_drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    aipp_parser_axis_mc_if #(.TDATA_W(TDATA_W)) s_axis ();

    aipp_parser_axis_mc #(
        .TDATA_W(TDATA_W), .N_CH(N_CH), .FIFO_DEPTH(FIFO_DEPTH),
        .TRIG_CYC(TRIG_CYC), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis(s_axis),
        .m_cmd_tvalid(m_cmd_tvalid),
        .m_cmd_tready(m_cmd_tready),
        .m_cmd_delay_us(m_cmd_delay_us),
        .m_cmd_voltage_mv(m_cmd_voltage_mv),
        .m_cmd_chan(m_cmd_chan),
        .trigger_out(trigger_out),
        .fifo_level(fifo_level),
        .pkt_ok_cnt(pkt_ok_cnt),
        .pkt_drop_cnt(pkt_drop_cnt)
    );

    always #5 aclk = ~aclk;

    function automatic logic [127:0] mk_hdr(input logic [7:0] op, input logic [31:0] dly,
                                            input logic [31:0] mv, input logic [3:0] ch);
        return {52'd0, ch, mv, dly, op};
    endfunction

    // Presents one beat from a falling edge and returns 1 time unit after it is accepted.
    task automatic send_beat(input logic [63:0] d, input logic l);
        int n = 0;
        @(negedge aclk);
        s_axis.tdata = d; s_axis.tlast = l; s_axis.tvalid = 1'b1;
        while (!s_axis.tready && n < 200) begin @(negedge aclk); n++; end
        vectors++;
        if (!s_axis.tready) begin
            $display("FAIL beat_accept_timeout: tready=%0b after %0d cycles, want 1", s_axis.tready, n);
            miscompares++;
        end
        @(posedge aclk); #1;
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    endtask

    task automatic send_pkt(input logic [127:0] h);
        send_beat(h[63:0], 1'b0);
        send_beat(h[127:64], 1'b1);
    endtask

    task automatic pop_one();
        @(negedge aclk); m_cmd_tready = 1'b1;
        @(posedge aclk); #1; m_cmd_tready = 1'b0;
    endtask

    task automatic test_reset();
        s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        #2 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        vectors++; if (s_axis.tready !== 1'b1) begin $display("FAIL rst_tready: got %0b want 1", s_axis.tready); miscompares++; end
        vectors++; if (m_cmd_tvalid !== 1'b0) begin $display("FAIL rst_tvalid: got %0b want 0", m_cmd_tvalid); miscompares++; end
        vectors++; if (fifo_level !== 4'd0) begin $display("FAIL rst_level: got %0d want 0", fifo_level); miscompares++; end
        vectors++; if (trigger_out !== 4'b0) begin $display("FAIL rst_trigger: got %b want 0000", trigger_out); miscompares++; end
        vectors++; if (pkt_ok_cnt !== 16'd0 || pkt_drop_cnt !== 16'd0) begin $display("FAIL rst_counters: got ok=%0d drop=%0d want 0/0", pkt_ok_cnt, pkt_drop_cnt); miscompares++; end
        vectors++; if (m_cmd_delay_us !== 32'd0 || m_cmd_voltage_mv !== 32'd0 || m_cmd_chan !== 4'd0) begin $display("FAIL rst_cmd_fields: got %0h/%0h/%0h want 0", m_cmd_delay_us, m_cmd_voltage_mv, m_cmd_chan); miscompares++; end
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [127:0] h;
        h = mk_hdr(8'h10, 32'd100, 32'd3200, 4'd2);
        send_pkt(h);
        vectors++; if (m_cmd_tvalid !== 1'b1) begin $display("FAIL basic_latency: tvalid got %0b want 1", m_cmd_tvalid); miscompares++; end
        vectors++; if (m_cmd_delay_us !== 32'd100) begin $display("FAIL basic_delay: got %0d want 100", m_cmd_delay_us); miscompares++; end
        vectors++; if (m_cmd_voltage_mv !== 32'd3200) begin $display("FAIL basic_voltage: got %0d want 3200", m_cmd_voltage_mv); miscompares++; end
        vectors++; if (m_cmd_chan !== 4'd2) begin $display("FAIL basic_chan: got %0d want 2", m_cmd_chan); miscompares++; end
        vectors++; if (fifo_level !== 4'd1 || pkt_ok_cnt !== 16'd1) begin $display("FAIL basic_level_ok: got level=%0d ok=%0d want 1/1", fifo_level, pkt_ok_cnt); miscompares++; end
        vectors++; if (trigger_out !== 4'b0) begin $display("FAIL basic_trig_before_pop: got %b want 0000", trigger_out); miscompares++; end
        pop_one();
        for (int i = 0; i < TRIG_CYC; i++) begin
            vectors++; if (trigger_out !== 4'b0100) begin $display("FAIL basic_trig_pulse[%0d]: got %b want 0100", i, trigger_out); miscompares++; end
            @(posedge aclk); #1;
        end
        vectors++; if (trigger_out !== 4'b0) begin $display("FAIL basic_trig_end: got %b want 0000", trigger_out); miscompares++; end
        vectors++; if (fifo_level !== 4'd0 || m_cmd_tvalid !== 1'b0) begin $display("FAIL basic_drained: got level=%0d tvalid=%0b want 0/0", fifo_level, m_cmd_tvalid); miscompares++; end
    endtask

    task automatic test_drop();
        send_pkt(mk_hdr(8'h20, 32'd5, 32'd6, 4'd1));
        send_pkt(mk_hdr(8'h10, 32'd5, 32'd6, 4'd7));
        repeat (2) @(posedge aclk); #1;
        vectors++; if (pkt_drop_cnt !== 16'd2) begin $display("FAIL drop_cnt: got %0d want 2", pkt_drop_cnt); miscompares++; end
        vectors++; if (pkt_ok_cnt !== 16'd1) begin $display("FAIL drop_ok_cnt: got %0d want 1", pkt_ok_cnt); miscompares++; end
        vectors++; if (fifo_level !== 4'd0 || m_cmd_tvalid !== 1'b0) begin $display("FAIL drop_no_push: got level=%0d tvalid=%0b want 0/0", fifo_level, m_cmd_tvalid); miscompares++; end
        vectors++; if (trigger_out !== 4'b0) begin $display("FAIL drop_trigger: got %b want 0000", trigger_out); miscompares++; end
    endtask

    task automatic test_payload();
        logic [127:0] h1, p, h2;
        h1 = mk_hdr(8'h10, 32'd500, 32'd1800, 4'd1);
        h1[127:76] = '1;
        p  = mk_hdr(8'h10, 32'd999, 32'd0, 4'd0);
        h2 = mk_hdr(8'h10, 32'd600, 32'd2500, 4'd3);
        send_beat(h1[63:0], 1'b0);
        send_beat(h1[127:64], 1'b0);
        send_beat(p[63:0], 1'b1);
        send_pkt(h2);
        vectors++; if (fifo_level !== 4'd2 || pkt_ok_cnt !== 16'd3 || pkt_drop_cnt !== 16'd2) begin $display("FAIL payload_counts: got level=%0d ok=%0d drop=%0d want 2/3/2", fifo_level, pkt_ok_cnt, pkt_drop_cnt); miscompares++; end
        vectors++; if (m_cmd_chan !== 4'd1 || m_cmd_delay_us !== 32'd500) begin $display("FAIL payload_head0: got chan=%0d delay=%0d want 1/500", m_cmd_chan, m_cmd_delay_us); miscompares++; end
        pop_one();
        vectors++; if (m_cmd_chan !== 4'd3 || m_cmd_delay_us !== 32'd600 || m_cmd_voltage_mv !== 32'd2500) begin $display("FAIL payload_head1: got chan=%0d delay=%0d mv=%0d want 3/600/2500", m_cmd_chan, m_cmd_delay_us, m_cmd_voltage_mv); miscompares++; end
        pop_one();
        vectors++; if (trigger_out !== 4'b1010) begin $display("FAIL payload_concurrent_trig: got %b want 1010", trigger_out); miscompares++; end
        repeat (6) @(posedge aclk); #1;
        vectors++; if (trigger_out !== 4'b0 || fifo_level !== 4'd0) begin $display("FAIL payload_settle: got trig=%b level=%0d want 0000/0", trigger_out, fifo_level); miscompares++; end
    endtask

    task automatic test_full();
        int k = 0;
        int n = 0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            send_pkt(mk_hdr(8'h10, 32'(1000 + i), 32'(2000 + i), 4'(i % 4)));
        vectors++; if (fifo_level !== 4'd8) begin $display("FAIL full_level: got %0d want 8", fifo_level); miscompares++; end
        vectors++; if (s_axis.tready !== 1'b0) begin $display("FAIL full_tready: got %0b want 0", s_axis.tready); miscompares++; end
        fork
            send_pkt(mk_hdr(8'h10, 32'd1008, 32'd2008, 4'd0));
            begin
                repeat (3) @(negedge aclk);
                vectors++; if (s_axis.tready !== 1'b0 || fifo_level !== 4'd8) begin $display("FAIL full_hold: got tready=%0b level=%0d want 0/8", s_axis.tready, fifo_level); miscompares++; end
                m_cmd_tready = 1'b1;
                while (k < 9 && n < 100) begin
                    if (m_cmd_tvalid) begin
                        vectors++;
                        if (m_cmd_delay_us !== 32'(1000 + k) || m_cmd_voltage_mv !== 32'(2000 + k)) begin
                            $display("FAIL full_order[%0d]: got delay=%0d mv=%0d want %0d/%0d", k, m_cmd_delay_us, m_cmd_voltage_mv, 1000 + k, 2000 + k);
                            miscompares++;
                        end
                        k++;
                    end
                    @(negedge aclk); n++;
                end
                m_cmd_tready = 1'b0;
            end
        join
        vectors++; if (k !== 9) begin $display("FAIL full_pop_count: got %0d want 9", k); miscompares++; end
        vectors++; if (fifo_level !== 4'd0 || pkt_ok_cnt !== 16'd12) begin $display("FAIL full_final: got level=%0d ok=%0d want 0/12", fifo_level, pkt_ok_cnt); miscompares++; end
    endtask

    task automatic test_short();
        logic [127:0] p, h;
        p = mk_hdr(8'h10, 32'd1, 32'd1, 4'd0);
        h = mk_hdr(8'h10, 32'd55, 32'd700, 4'd0);
        send_beat(p[63:0], 1'b1);
        vectors++; if (pkt_drop_cnt !== 16'd3 || fifo_level !== 4'd0) begin $display("FAIL short_drop: got drop=%0d level=%0d want 3/0", pkt_drop_cnt, fifo_level); miscompares++; end
        send_pkt(h);
        vectors++; if (fifo_level !== 4'd1 || pkt_ok_cnt !== 16'd13) begin $display("FAIL short_next_counts: got level=%0d ok=%0d want 1/13", fifo_level, pkt_ok_cnt); miscompares++; end
        vectors++; if (m_cmd_delay_us !== 32'd55 || m_cmd_voltage_mv !== 32'd700 || m_cmd_chan !== 4'd0) begin $display("FAIL short_next_fields: got %0d/%0d/%0d want 55/700/0", m_cmd_delay_us, m_cmd_voltage_mv, m_cmd_chan); miscompares++; end
        pop_one();
        repeat (6) @(posedge aclk); #1;
    endtask

    task automatic test_reset_mid();
        logic [127:0] x, h;
        x = mk_hdr(8'h10, 32'd88, 32'd88, 4'd3);
        h = mk_hdr(8'h10, 32'd77, 32'd1500, 4'd1);
        send_pkt(mk_hdr(8'h10, 32'd11, 32'd1, 4'd0));
        send_pkt(mk_hdr(8'h10, 32'd22, 32'd2, 4'd1));
        send_pkt(mk_hdr(8'h10, 32'd33, 32'd3, 4'd2));
        pop_one();
        send_beat(x[63:0], 1'b0);
        vectors++; if (fifo_level !== 4'd2 || trigger_out !== 4'b0001) begin $display("FAIL rmid_pre: got level=%0d trig=%b want 2/0001", fifo_level, trigger_out); miscompares++; end
        @(negedge aclk); aresetn = 1'b0; #1;
        vectors++; if (fifo_level !== 4'd0 || m_cmd_tvalid !== 1'b0 || s_axis.tready !== 1'b1) begin $display("FAIL rmid_fifo: got level=%0d tvalid=%0b tready=%0b want 0/0/1", fifo_level, m_cmd_tvalid, s_axis.tready); miscompares++; end
        vectors++; if (trigger_out !== 4'b0 || pkt_ok_cnt !== 16'd0 || pkt_drop_cnt !== 16'd0) begin $display("FAIL rmid_outputs: got trig=%b ok=%0d drop=%0d want 0000/0/0", trigger_out, pkt_ok_cnt, pkt_drop_cnt); miscompares++; end
        vectors++; if (m_cmd_delay_us !== 32'd0 || m_cmd_chan !== 4'd0) begin $display("FAIL rmid_fields: got delay=%0d chan=%0d want 0/0", m_cmd_delay_us, m_cmd_chan); miscompares++; end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        send_pkt(h);
        vectors++; if (fifo_level !== 4'd1 || pkt_ok_cnt !== 16'd1 || pkt_drop_cnt !== 16'd0) begin $display("FAIL rmid_fresh_counts: got level=%0d ok=%0d drop=%0d want 1/1/0", fifo_level, pkt_ok_cnt, pkt_drop_cnt); miscompares++; end
        vectors++; if (m_cmd_delay_us !== 32'd77 || m_cmd_voltage_mv !== 32'd1500 || m_cmd_chan !== 4'd1) begin $display("FAIL rmid_fresh_fields: got %0d/%0d/%0d want 77/1500/1", m_cmd_delay_us, m_cmd_voltage_mv, m_cmd_chan); miscompares++; end
        pop_one();
        vectors++; if (trigger_out !== 4'b0010) begin $display("FAIL rmid_fresh_trig: got %b want 0010", trigger_out); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_payload();
        test_full();
        test_short();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end
endmodule
